// File: rtl/kernel_sched_rr_if.sv
// Bus bundle for kernel_sched_rr: requester, kernel and result handshakes.
// Define KSCHED_PERF_CNT_EN to add the perf_jobs / perf_stall counters.
interface kernel_sched_rr_if #(
  parameter int N_REQ = 4,
  parameter int TAG_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_sign;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         k_data;
  logic               k_sign;
  logic               k_valid;
  logic [9:0]         k_result;
  logic               k_result_valid;
  logic               res_valid;
  logic [9:0]         res_data;
  logic [TAG_W-1:0]   res_tag;
  logic               res_ready;
  logic               busy;
  logic               err;
`ifdef KSCHED_PERF_CNT_EN
  logic [15:0]        perf_jobs;
  logic [15:0]        perf_stall;

  modport master (
    input  req_valid, req_data, req_sign,
    input  k_result, k_result_valid, res_ready,
    output req_ready, k_data, k_sign, k_valid,
    output res_valid, res_data, res_tag,
    output busy, err, perf_jobs, perf_stall
  );

  modport slave (
    output req_valid, req_data, req_sign,
    output k_result, k_result_valid, res_ready,
    input  req_ready, k_data, k_sign, k_valid,
    input  res_valid, res_data, res_tag,
    input  busy, err, perf_jobs, perf_stall
  );
`else
  modport master (
    input  req_valid, req_data, req_sign,
    input  k_result, k_result_valid, res_ready,
    output req_ready, k_data, k_sign, k_valid,
    output res_valid, res_data, res_tag,
    output busy, err
  );

  modport slave (
    output req_valid, req_data, req_sign,
    output k_result, k_result_valid, res_ready,
    input  req_ready, k_data, k_sign, k_valid,
    input  res_valid, res_data, res_tag,
    input  busy, err
  );
`endif
endinterface

// File: rtl/kernel_sched_rr.sv
// Round-robin scheduler sharing one non-pipelined compute kernel.
// Optional KSCHED_PERF_CNT_EN adds saturating job/stall counters.
module kernel_sched_rr #(
  parameter int N_REQ   = 4,
  parameter int TAG_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  kernel_sched_rr_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       kd_q, kd_d;
  logic             ks_q, ks_d;
  logic             kv_q, kv_d;
  logic             rv_q, rv_d;
  logic [9:0]       rd_q, rd_d;
  logic             err_q, err_d;

  logic             any;
  logic             grant;
  logic [TAG_W-1:0] gidx;
  logic [TAG_W-1:0] gnext;
  logic [TAG_W:0]   sum;
  logic [TAG_W-1:0] cand;

  // First set req_valid at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    any  = 1'b0;
    gidx = '0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(N_REQ)) begin
        sum = sum - (TAG_W+1)'(N_REQ);
      end
      cand = sum[TAG_W-1:0];
      if (!any && bus.req_valid[cand]) begin
        any  = 1'b1;
        gidx = cand;
      end
    end
  end

  assign grant = any && ((state_q == IDLE) ||
                 ((state_q == DONE) && bus.res_ready));

  assign gnext = (gidx == TAG_W'(N_REQ - 1)) ?
                 '0 : gidx + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[gidx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    rtag_d  = rtag_q;
    cnt_d   = cnt_q;
    kd_d    = kd_q;
    ks_d    = ks_q;
    kv_d    = 1'b0;
    rv_d    = rv_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ISSUE: begin
        // Result-valid may still be high from the last job here.
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (bus.k_result_valid) begin
          rv_d    = 1'b1;
          rd_d    = bus.k_result;
          rtag_d  = tag_q;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (grant) begin
      state_d = ISSUE;
      ptr_d   = gnext;
      tag_d   = gidx;
      kd_d    = bus.req_data[{gidx, 3'b000} +: 8];
      ks_d    = bus.req_sign[gidx];
      kv_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      rtag_q  <= '0;
      cnt_q   <= '0;
      kd_q    <= '0;
      ks_q    <= 1'b0;
      kv_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      rtag_q  <= rtag_d;
      cnt_q   <= cnt_d;
      kd_q    <= kd_d;
      ks_q    <= ks_d;
      kv_q    <= kv_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign bus.k_data    = kd_q;
  assign bus.k_sign    = ks_q;
  assign bus.k_valid   = kv_q;
  assign bus.res_valid = rv_q;
  assign bus.res_data  = rd_q;
  assign bus.res_tag   = rtag_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

`ifdef KSCHED_PERF_CNT_EN
  logic [15:0] pj_q, pj_d;
  logic [15:0] ps_q, ps_d;

  always_comb begin
    pj_d = pj_q;
    ps_d = ps_q;
    if (state_q == DONE) begin
      if (bus.res_ready) begin
        if (pj_q != 16'hFFFF) pj_d = pj_q + 16'd1;
      end else begin
        if (ps_q != 16'hFFFF) ps_d = ps_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pj_q <= '0;
      ps_q <= '0;
    end else begin
      pj_q <= pj_d;
      ps_q <= ps_d;
    end
  end

  assign bus.perf_jobs  = pj_q;
  assign bus.perf_stall = ps_q;
`endif

endmodule

// File: doc/kernel_sched_rr.md
# kernel_sched_rr

Round-robin scheduler that shares one non-pipelined 8-bit approximate computing kernel (10-bit result, 4-cycle compute) between N_REQ requesters. Each requester hands over one operand (|t| fraction + sign) with a valid/ready handshake. The scheduler issues it to the kernel, waits for the kernel result and returns it on a single tagged valid/ready result port. It sits between the operand producers and the kernel instance, and owns the kernel's iDataValid strobe.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- TAG_W, $clog2(N_REQ): width of the result tag.
- TIMEOUT, 15: maximum WAIT cycles before the job is abandoned, 6..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  8*N_REQ  operand i at [8i+7:8i], {0,8} fraction.
- req_sign  in  N_REQ  operand sign, 1 = negative.
- req_ready  out  N_REQ  one-hot grant; a handshake completes when req_valid[i] and req_ready[i] are both high.
- k_data  out  8  kernel iData, registered.
- k_sign  out  1  kernel iSign, registered.
- k_valid  out  1  kernel iDataValid, registered, one-cycle pulse.
- k_result  in  10  kernel oData, {2,8}.
- k_result_valid  in  1  kernel oDataValid. It stays high after a job until the next k_valid.
- res_valid  out  1  result valid.
- res_data  out  10  result, {2,8}.
- res_tag  out  TAG_W  index of the requester that owns res_data.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid is set, grant requester g and go to ISSUE.
  - req_ready[g]=1 combinationally in that cycle.
  - At the clock edge: k_data, k_sign, tag ← requester g; k_valid ← 1.
- Round-robin:
  - Search starts at ptr; g is the first set req_valid at or after ptr, wrapping modulo N_REQ.
  - On a grant, ptr ← (g+1) mod N_REQ.
  - At most one req_ready bit is high in any cycle.
- ISSUE: k_valid=1 for exactly this cycle; go to WAIT. k_result_valid is ignored in ISSUE, because it may still be high from the previous job.
- WAIT:
  - A counter counts WAIT cycles.
  - If k_result_valid=1: res_data ← k_result, res_tag ← tag, res_valid ← 1; go to DONE.
  - Otherwise, if the counter reaches TIMEOUT: err ← 1; drop the job with no result; go to IDLE.
- DONE:
  - res_valid, res_data and res_tag stay stable until res_ready=1.
  - When res_ready=1, res_valid ← 0. If any req_valid is also set in the same cycle, grant per round-robin (req_ready asserted) and go to ISSUE; otherwise go to IDLE.
- Requests are never granted in ISSUE or WAIT, or in DONE without res_ready.
- k_data and k_sign hold their last value between jobs.

## Timing
- Reset values: all outputs 0; ptr=0; state IDLE; WAIT counter 0; err 0.
- Grant in cycle T0 → k_valid in T0+1 (ISSUE) → k_result_valid expected in T0+6 → res_valid from T0+7.
- Minimum job period with res_ready held high and requests pending is 7 cycles: grant in DONE, then ISSUE, then 5 WAIT cycles.
- req_valid dropping before a grant: no grant, no side effect.
- Reset asserted mid-job: everything returns to reset values immediately. The result of the in-flight job is lost.
- res_ready high while res_valid=0 has no effect.

## Configuration
- KSCHED_PERF_CNT_EN defined adds two outputs, both reset to 0 and saturating at 16'hFFFF:
  - perf_jobs [15:0]: increments on each result handshake.
  - perf_stall [15:0]: increments each cycle in DONE with res_ready=0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Single job, kernel model with 4-cycle compute: requester 2 sends data 8'h40, sign 0; res_ready=1 → req_ready[2] for one cycle, k_valid one cycle later, res_valid 6 cycles after k_valid with res_data = kernel output, res_tag=2.
- All four requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0; one job every 7 cycles; tags match.
- Stale valid: kernel result-valid held high across jobs → the new result is captured only after the kernel deasserts and reasserts it; the stale value is never captured in ISSUE.
- Backpressure: res_ready=0 for 10 cycles in DONE → res_valid and res_data stable, no req_ready; on release, the grant happens in the same cycle.
- Timeout: the kernel never asserts result-valid → err=1 after 15 WAIT cycles; FSM back in IDLE; the next job completes normally with err still 1.
- Reset during WAIT → all outputs 0 next cycle; ptr=0; the first grant after release goes to the lowest valid index.
